// File: rtl/tlb_cp0_ctrl.sv
// CP0 TLB register file (Index/Random/EntryLo0/1/PageMask/Wired/EntryHi) and TLBR/TLBWI/TLBWR/TLBP sequencer.
// Optional Wired register: define TLB_CP0_WIRED_EN; otherwise Wired reads 0 and Random spans all entries.
module tlb_cp0_ctrl #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  output logic             op_ready,
  output logic             op_done,
  input  logic             mtc0_we,
  input  logic [4:0]       mtc0_addr,
  input  logic [31:0]      mtc0_wdata,
  input  logic [4:0]       mfc0_addr,
  output logic [31:0]      mfc0_rdata,
  input  logic             exc_tlb,
  input  logic [31:0]      exc_vaddr,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_windex,
  output logic [31:0]      tlb_entryhi,
  output logic [31:0]      tlb_pagemask,
  output logic [31:0]      tlb_entrylo0,
  output logic [31:0]      tlb_entrylo1,
  output logic [IDX_W-1:0] tlb_rd_index,
  input  logic [31:0]      tlb_rd_entryhi,
  input  logic [31:0]      tlb_rd_pagemask,
  input  logic [31:0]      tlb_rd_entrylo0,
  input  logic [31:0]      tlb_rd_entrylo1,
  input  logic [31:0]      tlb_probe_index
);
  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWI = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;

  localparam logic [31:0] IDX_MASK   = 32'((1 << IDX_W) - 1);
  localparam logic [31:0] PROBE_MASK = 32'h8000_0000 | IDX_MASK;
  localparam logic [31:0] LO_MASK    = 32'h03FF_FFFF;
  localparam logic [31:0] PM_MASK    = 32'h01FF_E000;
  localparam logic [31:0] VPN2_MASK  = 32'hFFFF_E000;
  localparam logic [31:0] ASID_MASK  = 32'h0000_00FF;
  localparam logic [IDX_W-1:0] RND_TOP = IDX_W'(ENTRIES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state_q;
  logic             op_ready_q, op_done_q, tlb_we_q;
  logic [IDX_W-1:0] tlb_windex_q;
  logic [1:0]       op_code_q;

  logic [31:0]      index_q, index_d, entrylo0_q, entrylo0_d, entrylo1_q, entrylo1_d;
  logic [31:0]      pagemask_q, pagemask_d, entryhi_q, entryhi_d;
  logic [IDX_W-1:0] random_q, random_d, wired_val;
  logic             mtc0_ok, wired_wr, capture_r, capture_p;

  assign mtc0_ok   = mtc0_we && (state_q == S_IDLE);
  assign capture_r = (state_q == S_EXEC) && (op_code_q == OP_TLBR);
  assign capture_p = (state_q == S_EXEC) && (op_code_q == OP_TLBP);

`ifdef TLB_CP0_WIRED_EN
  logic [IDX_W-1:0] wired_q, wired_d;
  assign wired_wr = mtc0_ok && (mtc0_addr == 5'd6);

  always_comb begin
    wired_d = wired_q;
    if (wired_wr) wired_d = mtc0_wdata[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) wired_q <= '0;
    else     wired_q <= wired_d;
  end

  assign wired_val = wired_q;
`else
  assign wired_wr  = 1'b0;
  assign wired_val = '0;
`endif

  always_comb begin
    if (wired_wr || (random_q <= wired_val)) random_d = RND_TOP;
    else                                      random_d = random_q - IDX_W'(1);
  end

  // Capture in EXEC beats exc_tlb, which beats mtc0; an mtc0 to Index never sets P.
  always_comb begin
    index_d    = index_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    pagemask_d = pagemask_q;
    entryhi_d  = entryhi_q;
    if (capture_p)
      index_d = tlb_probe_index & PROBE_MASK;
    else if (mtc0_ok && (mtc0_addr == 5'd0))
      index_d = mtc0_wdata & IDX_MASK;
    if (capture_r) begin
      entrylo0_d = tlb_rd_entrylo0 & LO_MASK;
      entrylo1_d = tlb_rd_entrylo1 & LO_MASK;
      pagemask_d = tlb_rd_pagemask & PM_MASK;
      entryhi_d  = tlb_rd_entryhi & (VPN2_MASK | ASID_MASK);
    end else begin
      if (mtc0_ok && (mtc0_addr == 5'd2)) entrylo0_d = mtc0_wdata & LO_MASK;
      if (mtc0_ok && (mtc0_addr == 5'd3)) entrylo1_d = mtc0_wdata & LO_MASK;
      if (mtc0_ok && (mtc0_addr == 5'd5)) pagemask_d = mtc0_wdata & PM_MASK;
      if (exc_tlb)
        entryhi_d = (exc_vaddr & VPN2_MASK) | (entryhi_q & ASID_MASK);
      else if (mtc0_ok && (mtc0_addr == 5'd10))
        entryhi_d = mtc0_wdata & (VPN2_MASK | ASID_MASK);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_q    <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      pagemask_q <= '0;
      entryhi_q  <= '0;
      random_q   <= RND_TOP;
    end else begin
      index_q    <= index_d;
      entrylo0_q <= entrylo0_d;
      entrylo1_q <= entrylo1_d;
      pagemask_q <= pagemask_d;
      entryhi_q  <= entryhi_d;
      random_q   <= random_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_ready_q   <= 1'b1;
      op_done_q    <= 1'b0;
      tlb_we_q     <= 1'b0;
      tlb_windex_q <= '0;
      op_code_q    <= OP_TLBR;
    end else begin
      op_done_q <= 1'b0;
      tlb_we_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (op_valid && op_ready_q) begin
            state_q      <= S_EXEC;
            op_ready_q   <= 1'b0;
            op_code_q    <= op_code;
            tlb_we_q     <= (op_code == OP_TLBWI) || (op_code == OP_TLBWR);
            tlb_windex_q <= (op_code == OP_TLBWR) ? random_q : index_q[IDX_W-1:0];
          end
        end
        S_EXEC: begin
          state_q   <= S_DONE;
          op_done_q <= 1'b1;
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          op_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          op_ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_addr)
      5'd0:    mfc0_rdata = index_q;
      5'd1:    mfc0_rdata = 32'(random_q);
      5'd2:    mfc0_rdata = entrylo0_q;
      5'd3:    mfc0_rdata = entrylo1_q;
      5'd5:    mfc0_rdata = pagemask_q;
      5'd6:    mfc0_rdata = 32'(wired_val);
      5'd10:   mfc0_rdata = entryhi_q;
      default: mfc0_rdata = '0;
    endcase
  end

  assign op_ready     = op_ready_q;
  assign op_done      = op_done_q;
  assign tlb_we       = tlb_we_q;
  assign tlb_windex   = tlb_windex_q;
  assign tlb_entryhi  = entryhi_q;
  assign tlb_pagemask = pagemask_q;
  assign tlb_entrylo0 = entrylo0_q;
  assign tlb_entrylo1 = entrylo1_q;
  assign tlb_rd_index = index_q[IDX_W-1:0];

endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// Directed bench for tlb_cp0_ctrl: register access, all four TLB ops, Random/Wired, priorities, busy and reset.
module tb_tlb_cp0_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic        op_ready, op_done;
  logic        mtc0_we = 1'b0;
  logic [4:0]  mtc0_addr = 5'd0;
  logic [31:0] mtc0_wdata = 32'd0;
  logic [4:0]  mfc0_addr = 5'd0;
  logic [31:0] mfc0_rdata;
  logic        exc_tlb = 1'b0;
  logic [31:0] exc_vaddr = 32'd0;
  logic        tlb_we;
  logic [4:0]  tlb_windex, tlb_rd_index;
  logic [31:0] tlb_entryhi, tlb_pagemask, tlb_entrylo0, tlb_entrylo1;
  logic [31:0] tlb_rd_entryhi = 32'd0, tlb_rd_pagemask = 32'd0;
  logic [31:0] tlb_rd_entrylo0 = 32'd0, tlb_rd_entrylo1 = 32'd0;
  logic [31:0] tlb_probe_index = 32'h8000_0000;

  int checks = 0;
  int errors = 0;

  // Reference Random/Wired behaviour, stepped on the same edges as the DUT.
  int exp_rnd = 31;
  int exp_wired = 0;

  tlb_cp0_ctrl #(.ENTRIES(32), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .op_done(op_done), .mtc0_we(mtc0_we),
    .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata), .mfc0_addr(mfc0_addr),
    .mfc0_rdata(mfc0_rdata), .exc_tlb(exc_tlb), .exc_vaddr(exc_vaddr),
    .tlb_we(tlb_we), .tlb_windex(tlb_windex), .tlb_entryhi(tlb_entryhi),
    .tlb_pagemask(tlb_pagemask), .tlb_entrylo0(tlb_entrylo0),
    .tlb_entrylo1(tlb_entrylo1), .tlb_rd_index(tlb_rd_index),
    .tlb_rd_entryhi(tlb_rd_entryhi), .tlb_rd_pagemask(tlb_rd_pagemask),
    .tlb_rd_entrylo0(tlb_rd_entrylo0), .tlb_rd_entrylo1(tlb_rd_entrylo1),
    .tlb_probe_index(tlb_probe_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      exp_rnd   <= 31;
      exp_wired <= 0;
    end
`ifdef TLB_CP0_WIRED_EN
    else if (mtc0_we && mtc0_addr == 5'd6) begin
      exp_rnd   <= 31;
      exp_wired <= int'(mtc0_wdata[4:0]);
    end
`endif
    else begin
      exp_rnd <= (exp_rnd <= exp_wired) ? 31 : exp_rnd - 1;
    end
  end

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d;
    @(negedge clk);
    mtc0_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    mfc0_addr = a;
    #1;
    d = mfc0_rdata;
  endtask

  // Called at an idle negedge; returns at the negedge inside EXEC.
  task automatic start_op(input logic [1:0] code);
    op_valid = 1'b1; op_code = code;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", op_ready); end
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", op_done); end
    checks++; if (tlb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", tlb_we); end
    rd(5'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_index: got %h want 0", v); end
    rd(5'd10, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_entryhi: got %h want 0", v); end
    rd(5'd1, v);
    checks++; if (v !== 32'd31) begin errors++; $display("FAIL reset_random: got %h want 1f", v); end
    rd(5'd6, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_wired: got %h want 0", v); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(5'd1, v);
    checks++; if (v !== 32'd30) begin errors++; $display("FAIL random_first_step: got %h want 1e", v); end
  endtask

  task automatic test_tlbwi_tlbr;
    logic [31:0] v;
    int we_cnt;
    mtc0(5'd0, 32'd5);
    mtc0(5'd10, 32'h1234_A0FF);
    mtc0(5'd2, 32'h0000_1047);
    mtc0(5'd3, 32'h0000_2047);
    mtc0(5'd5, 32'h0);
    rd(5'd10, v);
    checks++; if (v !== 32'h1234_A0FF) begin errors++; $display("FAIL mtc0_entryhi: got %h want 1234a0ff", v); end
    checks++; if (tlb_rd_index !== 5'd5) begin errors++; $display("FAIL rd_index: got %h want 05", tlb_rd_index); end
    start_op(2'b01);
    we_cnt = int'(tlb_we);
    checks++; if (tlb_windex !== 5'd5) begin errors++; $display("FAIL tlbwi_windex: got %h want 05", tlb_windex); end
    checks++; if (op_ready !== 1'b0 || op_done !== 1'b0) begin errors++; $display("FAIL exec_flags: got rdy=%b done=%b want 0 0", op_ready, op_done); end
    @(negedge clk);
    we_cnt += int'(tlb_we);
    checks++; if (op_done !== 1'b1 || op_ready !== 1'b0) begin errors++; $display("FAIL done_flags: got rdy=%b done=%b want 0 1", op_ready, op_done); end
    @(negedge clk);
    we_cnt += int'(tlb_we);
    checks++; if (op_ready !== 1'b1 || op_done !== 1'b0) begin errors++; $display("FAIL idle_flags: got rdy=%b done=%b want 1 0", op_ready, op_done); end
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL tlbwi_we_cycles: got %0d want 1", we_cnt); end
    // Clobber, then restore through TLBR with out-of-mask bits set on the read port.
    mtc0(5'd10, 32'h0);
    mtc0(5'd2, 32'h0);
    tlb_rd_entryhi = 32'h1234_BFFF; tlb_rd_entrylo0 = 32'h0000_1047;
    tlb_rd_entrylo1 = 32'hFFFF_2047; tlb_rd_pagemask = 32'hFFFF_FFFF;
    start_op(2'b00);
    checks++; if (tlb_we !== 1'b0) begin errors++; $display("FAIL tlbr_no_we: got %b want 0", tlb_we); end
    checks++; if (tlb_entryhi !== 32'h0) begin errors++; $display("FAIL tlbr_early: got %h want 0", tlb_entryhi); end
    @(negedge clk);
    rd(5'd10, v);
    checks++; if (v !== 32'h1234_A0FF) begin errors++; $display("FAIL tlbr_entryhi: got %h want 1234a0ff", v); end
    rd(5'd2, v);
    checks++; if (v !== 32'h0000_1047) begin errors++; $display("FAIL tlbr_entrylo0: got %h want 00001047", v); end
    rd(5'd3, v);
    checks++; if (v !== 32'h03FF_2047) begin errors++; $display("FAIL tlbr_entrylo1: got %h want 03ff2047", v); end
    rd(5'd5, v);
    checks++; if (v !== 32'h01FF_E000) begin errors++; $display("FAIL tlbr_pagemask: got %h want 01ffe000", v); end
    @(negedge clk);
  endtask

  task automatic test_tlbp;
    logic [31:0] v;
    tlb_probe_index = 32'h0000_0005;
    start_op(2'b11);
    repeat (2) @(negedge clk);
    rd(5'd0, v);
    checks++; if (v !== 32'h0000_0005) begin errors++; $display("FAIL tlbp_hit: got %h want 00000005", v); end
    tlb_probe_index = 32'h8000_0000;
    start_op(2'b11);
    repeat (2) @(negedge clk);
    rd(5'd0, v);
    checks++; if (v !== 32'h8000_0000) begin errors++; $display("FAIL tlbp_miss: got %h want 80000000", v); end
    mtc0(5'd0, 32'hFFFF_FFFF);
    rd(5'd0, v);
    checks++; if (v !== 32'h0000_001F) begin errors++; $display("FAIL index_mask: got %h want 0000001f", v); end
  endtask

  task automatic test_random;
    logic [31:0] v;
    int exp_w;
    int n;
`ifdef TLB_CP0_WIRED_EN
    mtc0(5'd6, 32'd30);
    rd(5'd6, v);
    checks++; if (v !== 32'd30) begin errors++; $display("FAIL wired_read: got %h want 1e", v); end
    for (int i = 0; i < 4; i++) begin
      rd(5'd1, v);
      checks++; if (v !== ((i % 2 == 0) ? 32'd31 : 32'd30)) begin errors++; $display("FAIL random_wired_%0d: got %h want %h", i, v, (i % 2 == 0) ? 31 : 30); end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      exp_w = exp_rnd;
      start_op(2'b10);
      checks++; if (tlb_we !== 1'b1 || int'(tlb_windex) !== exp_w || tlb_windex < 5'd30) begin errors++; $display("FAIL tlbwr_wired_%0d: got we=%b idx=%0d want we=1 idx=%0d", k, tlb_we, tlb_windex, exp_w); end
      repeat (2) @(negedge clk);
    end
`else
    mtc0(5'd6, 32'd30);
    rd(5'd6, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL wired_ignored: got %h want 0", v); end
    n = 0;
    while (exp_rnd != 0 && n < 40) begin @(negedge clk); n++; end
    rd(5'd1, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL random_bottom: got %h want 0", v); end
    @(negedge clk);
    rd(5'd1, v);
    checks++; if (v !== 32'd31) begin errors++; $display("FAIL random_wrap: got %h want 1f", v); end
    exp_w = exp_rnd;
    start_op(2'b10);
    checks++; if (tlb_we !== 1'b1 || int'(tlb_windex) !== exp_w) begin errors++; $display("FAIL tlbwr_index: got we=%b idx=%0d want we=1 idx=%0d", tlb_we, tlb_windex, exp_w); end
    repeat (2) @(negedge clk);
`endif
    rd(5'd1, v);
    checks++; if (int'(v) !== exp_rnd) begin errors++; $display("FAIL random_model: got %0d want %0d", v, exp_rnd); end
  endtask

  task automatic test_exc_collision;
    logic [31:0] v;
    mtc0(5'd10, 32'h0000_0042);
    exc_tlb = 1'b1; exc_vaddr = 32'hDEAD_B123;
    mtc0(5'd10, 32'h0);
    exc_tlb = 1'b0;
    rd(5'd10, v);
    checks++; if (v !== 32'hDEAD_A042) begin errors++; $display("FAIL exc_vs_mtc0: got %h want dead a042", v); end
    exc_tlb = 1'b1; exc_vaddr = 32'h0000_1FFF;
    @(negedge clk);
    exc_tlb = 1'b0;
    rd(5'd10, v);
    checks++; if (v !== 32'h0000_0042) begin errors++; $display("FAIL exc_low_vpn: got %h want 00000042", v); end
    tlb_rd_entryhi = 32'h1234_BFFF;
    start_op(2'b00);
    exc_tlb = 1'b1; exc_vaddr = 32'hFFFF_FFFF;
    @(negedge clk);
    exc_tlb = 1'b0;
    rd(5'd10, v);
    checks++; if (v !== 32'h1234_A0FF) begin errors++; $display("FAIL capture_vs_exc: got %h want 1234a0ff", v); end
    @(negedge clk);
  endtask

  task automatic test_busy;
    logic [31:0] v;
    mtc0(5'd0, 32'd3);
    start_op(2'b01);
    checks++; if (tlb_windex !== 5'd3) begin errors++; $display("FAIL busy_windex: got %h want 03", tlb_windex); end
    mtc0_we = 1'b1; mtc0_addr = 5'd0; mtc0_wdata = 32'd7;
    repeat (2) @(negedge clk);
    mtc0_we = 1'b0;
    rd(5'd0, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL busy_mtc0: got %h want 3", v); end
  endtask

  task automatic test_back_to_back;
    int we_cnt;
    int n;
    we_cnt = 0;
    op_valid = 1'b1; op_code = 2'b01;
    for (int i = 0; i < 9; i++) begin
      checks++; if (op_ready !== ((i % 3) == 0)) begin errors++; $display("FAIL b2b_ready_%0d: got %b want %b", i, op_ready, (i % 3) == 0); end
      we_cnt += int'(tlb_we);
      @(negedge clk);
    end
    op_valid = 1'b0;
    checks++; if (we_cnt !== 3) begin errors++; $display("FAIL b2b_writes: got %0d want 3", we_cnt); end
    n = 0;
    while (op_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_timeout: got %b want 1", op_ready); end
  endtask

  task automatic test_reset_exec;
    logic [31:0] v;
    mtc0(5'd10, 32'h0000_2000);
    tlb_rd_entryhi = 32'hFFFF_FFFF;
    start_op(2'b00);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (op_ready !== 1'b1 || op_done !== 1'b0 || tlb_we !== 1'b0) begin errors++; $display("FAIL rst_exec_flags: got rdy=%b done=%b we=%b want 1 0 0", op_ready, op_done, tlb_we); end
    rd(5'd10, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_exec_entryhi: got %h want 0", v); end
    rd(5'd1, v);
    checks++; if (v !== 32'd31) begin errors++; $display("FAIL rst_exec_random: got %h want 1f", v); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (op_done !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_after: got rdy=%b done=%b want 1 0", op_ready, op_done); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_tlbwi_tlbr;
    test_tlbp;
    test_random;
    test_exc_collision;
    test_busy;
    test_back_to_back;
    test_reset_exec;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
